// File: rtl/wb_regfile_stage.sv
// Writeback stage: EX/WB pipeline register feeding a 32 x 64-bit register file
// with byte-granular ppp/ww participation masks and per-byte read bypass.
// Big-endian bit numbering throughout: byte i occupies bits [8*i : 8*i+7].
module wb_regfile_stage #(
  parameter int NREG = 32,
  parameter int DW   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          ex_wrEN,
  input  logic [0:4]    ex_rd,
  input  logic [0:2]    ex_ppp,
  input  logic [0:1]    ex_ww,
  input  logic [0:63]   ex_data,
  input  logic [0:4]    rdAddrA,
  input  logic [0:4]    rdAddrB,
  output logic [0:63]   rdDataA,
  output logic [0:63]   rdDataB,
  output logic          wb_valid,
  output logic [0:4]    wb_rd,
  output logic [0:7]    wb_mask
);

  localparam int NB = DW / 8;

  // Participation field encodings.
  localparam logic [0:2] PPP_ALL  = 3'b000;
  localparam logic [0:2] PPP_UP   = 3'b001;
  localparam logic [0:2] PPP_DN   = 3'b010;
  localparam logic [0:2] PPP_EVEN = 3'b011;
  localparam logic [0:2] PPP_ODD  = 3'b100;

  logic [0:DW-1] regs [NREG];
  logic [0:DW-1] wb_data;
  logic [0:NB-1] ex_mask;

  // Replace the bytes of base selected by be with the matching bytes of data.
  function automatic logic [0:DW-1] merge_bytes(input logic [0:DW-1] base,
                                                input logic [0:DW-1] data,
                                                input logic [0:NB-1] be);
    logic [0:DW-1] r;
    r = base;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  // Decode the byte-enable mask from the participation field and element width.
  always_comb begin
    // NOTE: default first so every path assigns ex_mask and no latch is inferred.
    ex_mask = 8'h00;
    case (ex_ppp)
      PPP_ALL:  ex_mask = 8'hFF;
      PPP_UP:   ex_mask = 8'hF0;
      PPP_DN:   ex_mask = 8'h0F;
      PPP_EVEN: begin
        case (ex_ww)
          2'b00:   ex_mask = 8'hAA;
          2'b01:   ex_mask = 8'hCC;
          2'b10:   ex_mask = 8'hF0;
          default: ex_mask = 8'hFF;
        endcase
      end
      PPP_ODD: begin
        case (ex_ww)
          2'b00:   ex_mask = 8'h55;
          2'b01:   ex_mask = 8'h33;
          2'b10:   ex_mask = 8'h0F;
          default: ex_mask = 8'h00;
        endcase
      end
      default:  ex_mask = 8'h00;  // reserved encodings never write
    endcase
  end

  // EX/WB pipeline register: captures the ALU result unless stalled.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_mask  <= '0;
      wb_data  <= '0;
    end else if (!stall) begin
      wb_valid <= ex_wrEN && (ex_mask != 8'h00);
      wb_rd    <= ex_rd;
      wb_mask  <= ex_mask;
      wb_data  <= ex_data;
    end
  end

  // Register file commit: merge the pending write into its destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is cleared on reset so reads never return X; this is
      // deliberate and costs a reset path on every entry.
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (!stall && wb_valid) begin
      regs[wb_rd] <= merge_bytes(regs[wb_rd], wb_data, wb_mask);
    end
  end

  // Read ports: array data with per-byte bypass from the pending write.
  assign rdDataA = merge_bytes(regs[rdAddrA], wb_data,
                               (wb_valid && rdAddrA == wb_rd) ? wb_mask : 8'h00);
  assign rdDataB = merge_bytes(regs[rdAddrB], wb_data,
                               (wb_valid && rdAddrB == wb_rd) ? wb_mask : 8'h00);

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed testbench for wb_regfile_stage: reset state, mask decode table,
// bypass, byte merging, stall hold and reset during a pending write.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ex_wrEN;
  logic [0:4]  ex_rd;
  logic [0:2]  ex_ppp;
  logic [0:1]  ex_ww;
  logic [0:63] ex_data;
  logic [0:4]  rdAddrA;
  logic [0:4]  rdAddrB;
  logic [0:63] rdDataA;
  logic [0:63] rdDataB;
  logic        wb_valid;
  logic [0:4]  wb_rd;
  logic [0:7]  wb_mask;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile_stage dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .ex_wrEN (ex_wrEN),
    .ex_rd   (ex_rd),
    .ex_ppp  (ex_ppp),
    .ex_ww   (ex_ww),
    .ex_data (ex_data),
    .rdAddrA (rdAddrA),
    .rdAddrB (rdAddrB),
    .rdDataA (rdDataA),
    .rdDataB (rdDataB),
    .wb_valid(wb_valid),
    .wb_rd   (wb_rd),
    .wb_mask (wb_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_wrEN = 1'b0;
    ex_rd   = '0;
    ex_ppp  = '0;
    ex_ww   = '0;
    ex_data = '0;
  endtask

  // Present one write on the EX inputs and clock it into EX/WB.
  task automatic wr(input logic [4:0] rd, input logic [2:0] ppp, input logic [1:0] ww,
                    input logic [63:0] data);
    ex_wrEN = 1'b1;
    ex_rd   = rd;
    ex_ppp  = ppp;
    ex_ww   = ww;
    ex_data = data;
    tick();
  endtask

  // Hand-computed mask table indexed by {ppp, ww}.
  logic [7:0] mask_tbl [32];

  initial begin
    for (int k = 0; k < 32; k++) mask_tbl[k] = 8'h00;
    for (int w = 0; w < 4; w++) begin
      mask_tbl[{3'b000, w[1:0]}] = 8'hFF;
      mask_tbl[{3'b001, w[1:0]}] = 8'hF0;
      mask_tbl[{3'b010, w[1:0]}] = 8'h0F;
    end
    mask_tbl[{3'b011, 2'b00}] = 8'hAA;
    mask_tbl[{3'b011, 2'b01}] = 8'hCC;
    mask_tbl[{3'b011, 2'b10}] = 8'hF0;
    mask_tbl[{3'b011, 2'b11}] = 8'hFF;
    mask_tbl[{3'b100, 2'b00}] = 8'h55;
    mask_tbl[{3'b100, 2'b01}] = 8'h33;
    mask_tbl[{3'b100, 2'b10}] = 8'h0F;
    mask_tbl[{3'b100, 2'b11}] = 8'h00;

    reset   = 1'b1;
    stall   = 1'b0;
    rdAddrA = '0;
    rdAddrB = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state: every register reads zero on both ports.
    check("rst_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_mask", {56'd0, wb_mask}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rdAddrA = i[4:0];
      rdAddrB = 5'(31 - i);
      #1;
      check($sformatf("rst_A%0d", i), rdDataA, 64'd0);
      check($sformatf("rst_B%0d", 31 - i), rdDataB, 64'd0);
    end

    // Full write to r5: bypass before commit, array after.
    rdAddrA = 5'd5;
    wr(5, 3'b000, 2'b00, 64'h0123456789ABCDEF);
    idle();
    check("r5_valid", {63'd0, wb_valid}, 64'd1);
    check("r5_rd", {59'd0, wb_rd}, 64'd5);
    check("r5_mask", {56'd0, wb_mask}, 64'hFF);
    #1;
    check("r5_bypass", rdDataA, 64'h0123456789ABCDEF);
    tick();
    check("r5_valid_clr", {63'd0, wb_valid}, 64'd0);
    check("r5_array", rdDataA, 64'h0123456789ABCDEF);

    // Back-to-back merge into r7: fill, then even bytes cleared.
    rdAddrA = 5'd7;
    wr(7, 3'b000, 2'b00, 64'hFFFFFFFFFFFFFFFF);
    wr(7, 3'b011, 2'b00, 64'h0);
    idle();
    tick();
    check("r7_even_b", rdDataA, 64'h00FF00FF00FF00FF);
    wr(7, 3'b100, 2'b01, 64'h0);
    idle();
    tick();
    check("r7_odd_h", rdDataA, 64'h00FF000000FF0000);

    // Disjoint halves written back to back into r10.
    rdAddrB = 5'd10;
    wr(10, 3'b001, 2'b00, 64'h1111111111111111);
    wr(10, 3'b010, 2'b00, 64'h2222222222222222);
    idle();
    #1;
    check("r10_bypass", rdDataB, 64'h1111111122222222);
    tick();
    check("r10_merge", rdDataB, 64'h1111111122222222);

    // Stall holds the pending upper-half write to r3.
    rdAddrB = 5'd3;
    wr(3, 3'b001, 2'b00, 64'hAAAAAAAAAAAAAAAA);
    stall = 1'b1;
    ex_wrEN = 1'b1;
    ex_rd   = 5'd3;
    ex_ppp  = 3'b000;
    ex_data = 64'h5555555555555555;  // must not be captured while stalled
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_valid", c), {63'd0, wb_valid}, 64'd1);
      check($sformatf("stall%0d_mask", c), {56'd0, wb_mask}, 64'hF0);
      check($sformatf("stall%0d_bypass", c), rdDataB, 64'hAAAAAAAA00000000);
      check($sformatf("stall%0d_array", c), dut.regs[3], 64'd0);
    end
    stall = 1'b0;
    idle();
    tick();
    check("r3_commit", dut.regs[3], 64'hAAAAAAAA00000000);
    check("r3_valid_clr", {63'd0, wb_valid}, 64'd0);
    check("r3_read", rdDataB, 64'hAAAAAAAA00000000);

    // Reserved ppp and disabled writes leave r9 alone.
    rdAddrA = 5'd9;
    wr(9, 3'b101, 2'b00, 64'hFFFFFFFFFFFFFFFF);
    check("r9_rsvd_valid", {63'd0, wb_valid}, 64'd0);
    ex_wrEN = 1'b0;
    ex_ppp  = 3'b000;
    tick();
    check("r9_noen_valid", {63'd0, wb_valid}, 64'd0);
    idle();
    tick();
    check("r9_unchanged", rdDataA, 64'd0);

    // Mask decode across every ppp/ww combination (writes land in r31).
    for (int k = 0; k < 32; k++) begin
      wr(31, k[4:2], k[1:0], 64'h0);
      check($sformatf("mask_%0d_%0d", k >> 2, k & 3), {56'd0, wb_mask}, {56'd0, mask_tbl[k]});
      check($sformatf("mvalid_%0d_%0d", k >> 2, k & 3), {63'd0, wb_valid},
            {63'd0, (mask_tbl[k] != 8'h00)});
    end
    idle();
    tick();

    // Reset on the commit edge discards the pending write to r2.
    rdAddrA = 5'd2;
    rdAddrB = 5'd5;
    wr(2, 3'b000, 2'b00, 64'hDEADBEEFCAFEF00D);
    check("r2_pending", {63'd0, wb_valid}, 64'd1);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_valid", {63'd0, wb_valid}, 64'd0);
    check("rst2_mask", {56'd0, wb_mask}, 64'd0);
    check("rst2_r2", rdDataA, 64'd0);
    check("rst2_r5", rdDataB, 64'd0);
    wr(2, 3'b010, 2'b00, 64'h1234567890ABCDEF);
    idle();
    tick();
    check("r2_after_rst", rdDataA, 64'h0000000090ABCDEF);

    // Register 0 is an ordinary register.
    rdAddrB = 5'd0;
    wr(0, 3'b011, 2'b01, 64'hFEDCBA9876543210);
    idle();
    tick();
    check("r0_write", rdDataB, 64'hFEDC000076540000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
